cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_FU functional units.
- Each functional unit pushes completed results (dst tag + data) into its own small result FIFO.
- A round-robin arbiter picks one non-empty FIFO per cycle and drives a registered CDB broadcast. Reservation stations and the ROB snoop that broadcast for tag matches.
- Per-FU back-pressure is a stall signal raised when that FU's FIFO is full.

Parameters:
- DATA_WIDTH, 32, result data width.
- TAG_WIDTH, 6, destination tag width.
- NUM_FU, 4, number of requesting functional units (>=2).
- FIFO_DEPTH, 2, entries per result FIFO (power of two, >=2).

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- i_flush  in  1  pipeline flush; discards all queued results.
- i_fu_valid  in  NUM_FU  per-FU result valid.
- i_fu_tag  in  NUM_FU*TAG_WIDTH  per-FU dst tag; FU i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- i_fu_data  in  NUM_FU*DATA_WIDTH  per-FU result data, packed the same way.
- o_fu_stall  out  NUM_FU  per-FU stall; FIFO i is full.
- o_cdb_en  out  1  CDB broadcast valid.
- o_cdb_tag  out  TAG_WIDTH  broadcast tag.
- o_cdb_data  out  DATA_WIDTH  broadcast data.
- o_cdb_src  out  $clog2(NUM_FU)  index of the FU whose result is on the bus.

Behaviour:
- Reset (asynchronous, n_rst=0):
  - All FIFOs empty, counts 0.
  - o_cdb_en=0, o_cdb_tag=0, o_cdb_data=0, o_cdb_src=0.
  - o_fu_stall=0.
  - rr_last=NUM_FU-1, so FU0 has first priority.
- Push:
  - On a clock edge with i_fu_valid[i]=1 and o_fu_stall[i]=0, {tag,data} is written at FIFO i's tail.
  - A valid asserted while stall=1 is dropped. The FU must hold its result; a bench assertion flags this case.
- Stall:
  - o_fu_stall[i] = (count[i]==FIFO_DEPTH), decoded from registered count only.
  - A pop in the same cycle does not release stall; stall drops the cycle after count falls.
- Arbitration (combinational, each cycle):
  - Candidates are the non-empty FIFOs.
  - Grant the first candidate searching from rr_last+1 upward, wrapping modulo NUM_FU.
  - On a grant: pop that FIFO head and set rr_last=granted index at the edge.
  - With no candidates: no pop and rr_last unchanged.
- CDB output (registered):
  - On each edge, o_cdb_en<=grant_valid, o_cdb_tag/data<=granted head, o_cdb_src<=granted index.
  - With no grant, o_cdb_en<=0 and tag/data/src hold their previous values.
- Latency:
  - A result pushed at edge k is eligible during cycle k+1.
  - If granted, it is on the CDB after edge k+1, i.e. 1 cycle of o_cdb_en after the push cycle.
  - There is no same-cycle bypass.
- Ordering:
  - Per-FU results are broadcast in push order.
  - There is no ordering guarantee across FUs.
- Simultaneous push and pop on the same FIFO:
  - Both take effect and the count is unchanged.
  - With count 0, a push cannot be popped in the same cycle because the FIFO is seen as empty.
- Flush (synchronous, i_flush=1 at an edge):
  - All counts and pointers go to 0, o_cdb_en<=0, rr_last<=NUM_FU-1.
  - Pushes and grants in the flush cycle are discarded.
  - Flush has priority over push and pop.
- Reset mid-operation: all state returns to reset values immediately; queued results are lost.
- Wrap-around:
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - The count is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Add to the shared types package:
  - cdb_t packed struct {en, tag, data}, using package-level TAG_WIDTH/DATA_WIDTH localparams.
  - cdb_entry_t {tag, data}.
- Sub-module result_fifo (parameters DATA_WIDTH, TAG_WIDTH, DEPTH; ports clk, n_rst, i_flush, push, pop, din, dout, empty, full), instantiated NUM_FU times in a generate loop.
- The round-robin picker stays inline as a rotated priority search.

Test Plan:
- Reset, then FU2 pushes tag=5/data=0xDEAD at edge 1 -> after edge 2, o_cdb_en=1, tag=5, data=0xDEAD, src=2; after edge 3, o_cdb_en=0.
- All 4 FUs push (tags 1,2,3,4) in the same cycle -> CDB shows tags 1,2,3,4 with src 0,1,2,3 on four consecutive cycles.
- Arbitration fairness:
  - FU0 pushes every cycle while FU1 has 2 queued results.
  - Required: grants alternate 0,1,0,1 and FU1 is never starved.
- FU3 pushes 3 results back-to-back while FU0 continuously wins priority (DEPTH=2) -> o_fu_stall[3]=1 after its 2nd push. It falls 1 cycle after the first FU3 pop, and the 3rd push is accepted only then.
- Flush:
  - With FIFOs holding 5 results, assert i_flush for one cycle.
  - Required: o_cdb_en=0 from the next edge, no stale tags are ever broadcast, and the next push from FU1 appears with src=1 after 1 cycle.
- Assert n_rst=0 asynchronously mid-broadcast -> o_cdb_en drops immediately without waiting for a clock edge, and all stalls clear.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter: CDB payload and result-FIFO entry.
package cdb_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned TAG_WIDTH  = 6;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_entry_t;

    typedef struct packed {
        logic                  en;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_t;

endpackage

// File: rtl/result_fifo.sv
// Small per-FU result FIFO holding {tag, data}; flush empties it synchronously.
module result_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            i_flush,
    input  logic                            push,
    input  logic                            pop,
    input  logic [TAG_WIDTH+DATA_WIDTH-1:0] din,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] dout,
    output logic                            empty,
    output logic                            full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = TAG_WIDTH + DATA_WIDTH;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count only, so a same-cycle pop never frees a slot early.
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !i_flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB broadcast among NUM_FU result FIFOs.
module cdb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned NUM_FU     = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_flush,
    input  logic [NUM_FU-1:0]             i_fu_valid,
    input  logic [NUM_FU*TAG_WIDTH-1:0]   i_fu_tag,
    input  logic [NUM_FU*DATA_WIDTH-1:0]  i_fu_data,
    output logic [NUM_FU-1:0]             o_fu_stall,
    output logic                          o_cdb_en,
    output logic [TAG_WIDTH-1:0]          o_cdb_tag,
    output logic [DATA_WIDTH-1:0]         o_cdb_data,
    output logic [$clog2(NUM_FU)-1:0]     o_cdb_src
);
    import cdb_arbiter_pkg::*;

    localparam int unsigned      SRC_W   = $clog2(NUM_FU);
    localparam int unsigned      ENT_W   = TAG_WIDTH + DATA_WIDTH;
    localparam logic [SRC_W-1:0] RR_INIT = SRC_W'(NUM_FU - 1);

    logic [NUM_FU-1:0] fifo_empty;
    logic [NUM_FU-1:0] fifo_full;
    logic [NUM_FU-1:0] fifo_push;
    logic [NUM_FU-1:0] fifo_pop;
    cdb_entry_t        fifo_head [NUM_FU];

    logic              grant_valid_c;
    logic [SRC_W-1:0]  grant_idx_c;
    logic [SRC_W-1:0]  rr_last;
    cdb_t              cdb_q;
    logic [SRC_W-1:0]  src_q;

    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
        cdb_entry_t       entry_in;
        logic [ENT_W-1:0] entry_out;

        assign entry_in.tag   = i_fu_tag[gi*TAG_WIDTH +: TAG_WIDTH];
        assign entry_in.data  = i_fu_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign fifo_push[gi]  = i_fu_valid[gi] & ~fifo_full[gi];
        assign fifo_pop[gi]   = grant_valid_c & (grant_idx_c == SRC_W'(gi));
        assign fifo_head[gi]  = entry_out;

        result_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .n_rst   (n_rst),
            .i_flush (i_flush),
            .push    (fifo_push[gi]),
            .pop     (fifo_pop[gi]),
            .din     (entry_in),
            .dout    (entry_out),
            .empty   (fifo_empty[gi]),
            .full    (fifo_full[gi])
        );
    end

    assign o_fu_stall = fifo_full;

    // Rotated priority search: first non-empty FIFO after the last winner, wrapping.
    always_comb begin
        logic [SRC_W-1:0] cand;
        grant_valid_c = 1'b0;
        grant_idx_c   = '0;
        cand          = '0;
        for (int unsigned off = 1; off <= NUM_FU; off++) begin
            cand = SRC_W'((32'(rr_last) + off) % NUM_FU);
            if (!grant_valid_c && !fifo_empty[cand]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = cand;
            end
        end
    end

    // Broadcast register: payload and source hold when nothing is granted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cdb_q   <= '0;
            src_q   <= '0;
            rr_last <= RR_INIT;
        end else if (i_flush) begin
            cdb_q.en <= 1'b0;
            rr_last  <= RR_INIT;
        end else begin
            cdb_q.en <= grant_valid_c;
            if (grant_valid_c) begin
                cdb_q.tag  <= fifo_head[grant_idx_c].tag;
                cdb_q.data <= fifo_head[grant_idx_c].data;
                src_q      <= grant_idx_c;
                rr_last    <= grant_idx_c;
            end
        end
    end

    assign o_cdb_en   = cdb_q.en;
    assign o_cdb_tag  = cdb_q.tag;
    assign o_cdb_data = cdb_q.data;
    assign o_cdb_src  = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table plus model-driven sequences feeding a scoreboard queue.
module tb_cdb_arbiter;

    typedef struct packed {
        logic        en;
        logic [5:0]  tag;
        logic [31:0] data;
        logic [1:0]  src;
        logic [3:0]  stall;
    } exp_t;

    typedef struct packed {
        logic        fl;
        logic [3:0]  v;
        logic [23:0] tags;
        logic [31:0] dbase;
        exp_t        e;
    } vec_t;

    logic         clk;
    logic         n_rst;
    logic         i_flush;
    logic [3:0]   i_fu_valid;
    logic [23:0]  i_fu_tag;
    logic [127:0] i_fu_data;
    logic [3:0]   o_fu_stall;
    logic         o_cdb_en;
    logic [5:0]   o_cdb_tag;
    logic [31:0]  o_cdb_data;
    logic [1:0]   o_cdb_src;

    cdb_arbiter #(
        .DATA_WIDTH (32),
        .TAG_WIDTH  (6),
        .NUM_FU     (4),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_flush    (i_flush),
        .i_fu_valid (i_fu_valid),
        .i_fu_tag   (i_fu_tag),
        .i_fu_data  (i_fu_data),
        .o_fu_stall (o_fu_stall),
        .o_cdb_en   (o_cdb_en),
        .o_cdb_tag  (o_cdb_tag),
        .o_cdb_data (o_cdb_data),
        .o_cdb_src  (o_cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A producer must never present a result while its FU is stalled.
    assert property (@(posedge clk) disable iff (!n_rst) !(|(i_fu_valid & o_fu_stall)))
        else $error("valid asserted while stalled: valid=%b stall=%b", i_fu_valid, o_fu_stall);

    int   n_pass;
    int   n_checks;
    int   cyc;
    exp_t sb[$];

    // Reference model: shift-register queues of depth 2 per FU.
    logic [5:0]  m_tag  [4][2];
    logic [31:0] m_data [4][2];
    int          m_cnt  [4];
    int          m_rr;
    exp_t        m_last;

    int          pend [4];
    logic [5:0]  ntag [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_rr   = 3;
        m_last = '0;
    endtask

    task automatic model_step(input logic [3:0] v, input logic [23:0] t, input logic [127:0] d,
                              input logic fl, output exp_t e);
        logic [3:0] st;
        int g;
        for (int i = 0; i < 4; i++) st[i] = (m_cnt[i] == 2);
        e    = m_last;
        e.en = 1'b0;
        if (fl) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_rr = 3;
        end else begin
            g = -1;
            for (int k = 1; k <= 4; k++) begin
                int j;
                j = (m_rr + k) % 4;
                if (g < 0 && m_cnt[j] > 0) g = j;
            end
            if (g >= 0) begin
                e.en   = 1'b1;
                e.tag  = m_tag[g][0];
                e.data = m_data[g][0];
                e.src  = 2'(g);
                m_tag[g][0]  = m_tag[g][1];
                m_data[g][0] = m_data[g][1];
                m_cnt[g]--;
                m_rr = g;
            end
            for (int i = 0; i < 4; i++) begin
                if (v[i] && !st[i]) begin
                    m_tag[i][m_cnt[i]]  = t[i*6 +: 6];
                    m_data[i][m_cnt[i]] = d[i*32 +: 32];
                    m_cnt[i]++;
                end
            end
        end
        for (int i = 0; i < 4; i++) e.stall[i] = (m_cnt[i] == 2);
        m_last = e;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(1), 64'(0));
            return;
        end
        e = sb.pop_front();
        chk("cdb_en",   64'(o_cdb_en),   64'(e.en));
        chk("cdb_tag",  64'(o_cdb_tag),  64'(e.tag));
        chk("cdb_data", 64'(o_cdb_data), 64'(e.data));
        chk("cdb_src",  64'(o_cdb_src),  64'(e.src));
        chk("fu_stall", 64'(o_fu_stall), 64'(e.stall));
    endtask

    // One clock: drive at negedge, queue the expectation, compare just after the edge.
    task automatic drive(input logic fl, input logic [3:0] v, input logic [23:0] t,
                         input logic [127:0] d, input bit use_model, input exp_t te);
        exp_t e;
        @(negedge clk);
        i_flush    = fl;
        i_fu_valid = v;
        i_fu_tag   = t;
        i_fu_data  = d;
        if (use_model) begin
            model_step(v, t, d, fl, e);
            sb.push_back(e);
        end else begin
            sb.push_back(te);
        end
        @(posedge clk);
        #1;
        cyc++;
        check_out();
    endtask

    // Producers hold their next result until the FU is not stalled.
    task automatic tick(input logic fl);
        logic [3:0]   v;
        logic [23:0]  t;
        logic [127:0] d;
        v = '0;
        t = '0;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            if (pend[i] > 0 && m_cnt[i] != 2) begin
                v[i]         = 1'b1;
                t[i*6 +: 6]  = ntag[i];
                d[i*32 +: 32] = $urandom;
            end
        end
        drive(fl, v, t, d, 1'b1, '0);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                pend[i]--;
                ntag[i] = ntag[i] + 6'd1;
            end
        end
        if (fl) for (int i = 0; i < 4; i++) pend[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst      = 1'b0;
        i_flush    = 1'b0;
        i_fu_valid = '0;
        i_fu_tag   = '0;
        i_fu_data  = '0;
        @(negedge clk);
        n_rst = 1'b1;
        m_reset();
        for (int i = 0; i < 4; i++) pend[i] = 0;
    endtask

    function automatic logic [23:0] tg(input logic [5:0] t3, input logic [5:0] t2,
                                       input logic [5:0] t1, input logic [5:0] t0);
        return {t3, t2, t1, t0};
    endfunction

    function automatic exp_t ex(input logic en, input logic [5:0] tag, input logic [31:0] data,
                                input logic [1:0] src, input logic [3:0] stall);
        exp_t e;
        e.en    = en;
        e.tag   = tag;
        e.data  = data;
        e.src   = src;
        e.stall = stall;
        return e;
    endfunction

    function automatic vec_t mkv(input logic fl, input logic [3:0] v, input logic [23:0] tags,
                                 input logic [31:0] dbase, input exp_t e);
        vec_t r;
        r.fl    = fl;
        r.v     = v;
        r.tags  = tags;
        r.dbase = dbase;
        r.e     = e;
        return r;
    endfunction

    vec_t tbl [18];

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] d;
        n_pass     = 0;
        n_checks   = 0;
        cyc        = 0;
        n_rst      = 1'b0;
        i_flush    = 1'b0;
        i_fu_valid = '0;
        i_fu_tag   = '0;
        i_fu_data  = '0;
        m_reset();
        for (int i = 0; i < 4; i++) begin
            pend[i] = 0;
            ntag[i] = 6'(8 * i + 8);
        end

        // Single push, all-FU burst after flush, then two-FU fairness.
        tbl[0]  = mkv(1'b0, 4'b0100, tg(0, 5, 0, 0),         32'hDEA8, ex(1'b0, 6'd0,  32'h0,    2'd0, 4'b0000));
        tbl[1]  = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b1, 6'd5,  32'hDEAD, 2'd2, 4'b0000));
        tbl[2]  = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b0, 6'd5,  32'hDEAD, 2'd2, 4'b0000));
        tbl[3]  = mkv(1'b1, 4'b0000, '0,                      32'h0,    ex(1'b0, 6'd5,  32'hDEAD, 2'd2, 4'b0000));
        tbl[4]  = mkv(1'b0, 4'b1111, tg(4, 3, 2, 1),          32'h100,  ex(1'b0, 6'd5,  32'hDEAD, 2'd2, 4'b0000));
        tbl[5]  = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b1, 6'd1,  32'h101,  2'd0, 4'b0000));
        tbl[6]  = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b1, 6'd2,  32'h102,  2'd1, 4'b0000));
        tbl[7]  = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b1, 6'd3,  32'h103,  2'd2, 4'b0000));
        tbl[8]  = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b1, 6'd4,  32'h104,  2'd3, 4'b0000));
        tbl[9]  = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b0, 6'd4,  32'h104,  2'd3, 4'b0000));
        tbl[10] = mkv(1'b0, 4'b0011, tg(0, 0, 6'h30, 6'h20),  32'h1000, ex(1'b0, 6'd4,  32'h104,  2'd3, 4'b0000));
        tbl[11] = mkv(1'b0, 4'b0011, tg(0, 0, 6'h31, 6'h21),  32'h1000, ex(1'b1, 6'h20, 32'h1020, 2'd0, 4'b0010));
        tbl[12] = mkv(1'b0, 4'b0001, tg(0, 0, 0, 6'h22),      32'h1000, ex(1'b1, 6'h30, 32'h1030, 2'd1, 4'b0001));
        tbl[13] = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b1, 6'h21, 32'h1021, 2'd0, 4'b0000));
        tbl[14] = mkv(1'b0, 4'b0001, tg(0, 0, 0, 6'h23),      32'h1000, ex(1'b1, 6'h31, 32'h1031, 2'd1, 4'b0001));
        tbl[15] = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b1, 6'h22, 32'h1022, 2'd0, 4'b0000));
        tbl[16] = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b1, 6'h23, 32'h1023, 2'd0, 4'b0000));
        tbl[17] = mkv(1'b0, 4'b0000, '0,                      32'h0,    ex(1'b0, 6'h23, 32'h1023, 2'd0, 4'b0000));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_en",    64'(o_cdb_en),   64'(0));
        chk("rst_tag",   64'(o_cdb_tag),  64'(0));
        chk("rst_data",  64'(o_cdb_data), 64'(0));
        chk("rst_src",   64'(o_cdb_src),  64'(0));
        chk("rst_stall", 64'(o_fu_stall), 64'(0));
        n_rst = 1'b1;

        for (int r = 0; r < 18; r++) begin
            d = '0;
            for (int i = 0; i < 4; i++) d[i*32 +: 32] = tbl[r].dbase + 32'(tbl[r].tags[i*6 +: 6]);
            drive(tbl[r].fl, tbl[r].v, tbl[r].tags, d, 1'b0, tbl[r].e);
        end

        // FU3 overfills against FU0 traffic: stall, release, held third push.
        do_reset();
        pend[0] = 6;
        pend[3] = 3;
        repeat (14) tick(1'b0);

        // Flush with five results queued, then a fresh FU1 push.
        pend[0] = 2;
        pend[1] = 2;
        pend[2] = 1;
        pend[3] = 1;
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        repeat (3) tick(1'b0);
        pend[1] = 1;
        repeat (3) tick(1'b0);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 120; n++) begin
            for (int i = 0; i < 4; i++)
                if (pend[i] < 3 && $urandom_range(2) == 0) pend[i]++;
            tick(($urandom_range(15) == 0) ? 1'b1 : 1'b0);
        end
        pend[0] = 0; pend[1] = 0; pend[2] = 0; pend[3] = 0;
        repeat (10) tick(1'b0);

        // Asynchronous reset in the middle of a broadcast cycle.
        pend[0] = 4;
        pend[3] = 4;
        repeat (3) tick(1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_en",    64'(o_cdb_en),   64'(0));
        chk("arst_stall", 64'(o_fu_stall), 64'(0));
        chk("arst_tag",   64'(o_cdb_tag),  64'(0));
        chk("arst_src",   64'(o_cdb_src),  64'(0));
        @(negedge clk);
        i_fu_valid = '0;
        i_flush    = 1'b0;
        n_rst      = 1'b1;
        m_reset();
        for (int i = 0; i < 4; i++) pend[i] = 0;
        pend[2] = 1;
        repeat (3) tick(1'b0);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
